div_issue_ctrl: RTL

- Initiator side of the divider handshake (div_valid/div_ready, out_valid/quotient/remainder).
- Sits in EXU between the M-extension decode and the divider.
  - Accepts one DIV/DIVU/REM/REMU(/W) op at a time and drives the divider request.
  - Resolves the RISC-V divide-by-zero and signed-overflow cases locally, without issuing.
  - Selects and sign-extends the result, then holds it for writeback under a valid/ready handshake.

---
 rtl/div_issue_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/div_issue_ctrl.sv
// Divide-op issue controller: accepts one M-extension divide op, resolves divide-by-zero
// and signed overflow locally, otherwise drives the divider and holds the result for writeback.
module div_issue_ctrl #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            op_valid,
    output logic            op_ready,
    input  logic            op_rem,
    input  logic            op_signed,
    input  logic            op_w,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            div_valid,
    input  logic            div_ready,
    output logic            div_flush,
    output logic            divw,
    output logic            div_signed,
    output logic [XLEN-1:0] dividend,
    output logic [XLEN-1:0] divisor,
    input  logic            out_valid,
    input  logic [XLEN-1:0] quotient,
    input  logic [XLEN-1:0] remainder,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [XLEN-1:0] res_data
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state;
    state_t          state_nxt;
    logic            op_rem_q;
    logic            src2_zero;
    logic            ovf_case;
    logic            special;
    logic [XLEN-1:0] special_val;
    logic            accept;
    logic            capture;

    // W results are the low word sign-extended from bit 31
    function automatic logic [XLEN-1:0] fmt_result(input logic [XLEN-1:0] v, input logic w);
        fmt_result = w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
    endfunction

    always_comb begin
        if (op_w) begin
            src2_zero = (src2[31:0] == 32'd0);
            ovf_case  = op_signed && (src1[31:0] == 32'h8000_0000) && (src2[31:0] == 32'hFFFF_FFFF);
        end else begin
            src2_zero = (src2 == '0);
            ovf_case  = op_signed && (src1 == MOST_NEG) && (src2 == '1);
        end
        // divide-by-zero wins over overflow
        if (src2_zero) begin
            special_val = op_rem ? src1 : '1;
        end else if (ovf_case) begin
            special_val = op_rem ? '0 : src1;
        end else begin
            special_val = '0;
        end
        special = src2_zero | ovf_case;
    end

    assign accept  = (state == IDLE) && op_valid && !flush;
    assign capture = (state == WAIT) && out_valid && !flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (op_valid)  state_nxt = special ? DONE : ISSUE;
                ISSUE:   if (div_ready) state_nxt = WAIT;
                WAIT:    if (out_valid) state_nxt = DONE;
                DONE:    if (res_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // op_ready is held low while reset is asserted
    always_comb begin
        op_ready  = (state == IDLE) && rst;
        div_valid = (state == ISSUE);
        res_valid = (state == DONE);
        div_flush = flush && ((state == ISSUE) || (state == WAIT));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            divw       <= 1'b0;
            div_signed <= 1'b0;
            op_rem_q   <= 1'b0;
            dividend   <= '0;
            divisor    <= '0;
            res_data   <= '0;
        end else if (accept) begin
            divw       <= op_w;
            div_signed <= op_signed;
            op_rem_q   <= op_rem;
            dividend   <= src1;
            divisor    <= src2;
            if (special) begin
                res_data <= fmt_result(special_val, op_w);
            end
        end else if (capture) begin
            res_data <= fmt_result(op_rem_q ? remainder : quotient, divw);
        end
    end

endmodule
